// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock synchroniser, lock filter and ordered multi-channel reset release
module pll_reset_seq #(
  parameter int N_CH           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 16,
  parameter int STAGE_GAP      = 8,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic              clock_in,
  input  logic              rst_in,
  input  logic              pll_lock_in,
  input  logic              unlock_clr,
  output logic [N_CH-1:0]   rst_out,
  output logic              locked,
  output logic              pll_rst_out,
  output logic [CNT_W-1:0]  unlock_cnt,
  output logic              unlock_sticky
);

  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int PW = $clog2(PLL_RST_CYCLES + 1);

  localparam logic [TW-1:0]   T_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [FW-1:0]   F_LAST   = FW'(LOCK_FILTER - 1);
  localparam logic [GW-1:0]   G_LAST   = GW'(STAGE_GAP - 1);
  localparam logic [PW-1:0]   P_LAST   = PW'(PLL_RST_CYCLES);
  localparam logic [PW-1:0]   P_FIRST  = PW'(1);
  localparam logic [N_CH-1:0] ALL_ONES = '1;
  localparam logic [N_CH-1:0] TOP_ONLY = ALL_ONES ^ (ALL_ONES >> 1);

  typedef enum logic [1:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_SEQUENCE,
    S_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [N_CH-1:0]        rst_d;
  logic                   locked_d, pll_rst_d, sticky_d, lost;
  logic [CNT_W-1:0]       cnt_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_RESET_PLL;
      sync_q        <= '0;
      tcnt_q        <= '0;
      fcnt_q        <= '0;
      gcnt_q        <= '0;
      pcnt_q        <= '0;
      rst_out       <= '1;
      locked        <= 1'b0;
      pll_rst_out   <= 1'b1;
      unlock_cnt    <= '0;
      unlock_sticky <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_lock_in};
      tcnt_q        <= tcnt_d;
      fcnt_q        <= fcnt_d;
      gcnt_q        <= gcnt_d;
      pcnt_q        <= pcnt_d;
      rst_out       <= rst_d;
      locked        <= locked_d;
      pll_rst_out   <= pll_rst_d;
      unlock_cnt    <= cnt_d;
      unlock_sticky <= sticky_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    fcnt_d    = fcnt_q;
    gcnt_d    = gcnt_q;
    pcnt_d    = pcnt_q;
    rst_d     = rst_out;
    locked_d  = locked;
    pll_rst_d = pll_rst_out;
    lost      = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        pll_rst_d = 1'b1;
        if (pcnt_q == P_LAST) begin
          state_d   = S_WAIT_LOCK;
          pll_rst_d = 1'b0;
          pcnt_d    = '0;
          tcnt_d    = '0;
          fcnt_d    = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        tcnt_d = tcnt_q + 1'b1;
        fcnt_d = lock_s ? fcnt_q + 1'b1 : '0;
        // Lock acceptance takes priority over a timeout landing on the same edge.
        if (lock_s && fcnt_q == F_LAST) begin
          state_d  = (N_CH == 1) ? S_RUN : S_SEQUENCE;
          rst_d    = ALL_ONES << 1;
          locked_d = (N_CH == 1);
          gcnt_d   = '0;
        end else if (tcnt_q == T_LAST) begin
          state_d   = S_RESET_PLL;
          pll_rst_d = 1'b1;
          pcnt_d    = P_FIRST;  // the entry edge is the first pulse cycle
        end
      end
      S_SEQUENCE: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (gcnt_q == G_LAST) begin
          gcnt_d = '0;
          rst_d  = rst_out << 1;
          if (rst_out == TOP_ONLY) begin
            state_d  = S_RUN;
            locked_d = 1'b1;
          end
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) lost = 1'b1;
      end
      default: state_d = S_RESET_PLL;
    endcase

    if (lost) begin
      state_d  = S_WAIT_LOCK;
      rst_d    = ALL_ONES;
      locked_d = 1'b0;
      tcnt_d   = '0;
      fcnt_d   = '0;
    end

    // A clear on the same edge as a loss still records that loss.
    cnt_d    = unlock_clr ? '0 : unlock_cnt;
    sticky_d = unlock_clr ? 1'b0 : unlock_sticky;
    if (lost) begin
      if (!(&cnt_d)) cnt_d = cnt_d + 1'b1;
      sticky_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - randomized bench for pll_reset_seq against an edge-indexed reference model
module tb_pll_reset_seq;

  localparam int N    = 4;
  localparam int FILT = 16;
  localparam int GAP  = 8;
  localparam int TMO  = 1000;
  localparam int PCYC = 4;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       pll_lock_in = 1'b0;
  logic       unlock_clr = 1'b0;
  logic [3:0] rst_a, rst_b;
  logic       locked_a, locked_b, pll_a, pll_b, sticky_a, sticky_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  pll_reset_seq #(.N_CH(N), .SYNC_STAGES(2), .LOCK_FILTER(FILT), .STAGE_GAP(GAP),
                  .LOCK_TIMEOUT(TMO), .PLL_RST_CYCLES(PCYC), .CNT_W(8)) dut_a (
    .clock_in(clk), .rst_in(rst_in), .pll_lock_in(pll_lock_in), .unlock_clr(unlock_clr),
    .rst_out(rst_a), .locked(locked_a), .pll_rst_out(pll_a),
    .unlock_cnt(cnt_a), .unlock_sticky(sticky_a));

  pll_reset_seq #(.N_CH(N), .SYNC_STAGES(2), .LOCK_FILTER(FILT), .STAGE_GAP(GAP),
                  .LOCK_TIMEOUT(TMO), .PLL_RST_CYCLES(PCYC), .CNT_W(2)) dut_b (
    .clock_in(clk), .rst_in(rst_in), .pll_lock_in(pll_lock_in), .unlock_clr(unlock_clr),
    .rst_out(rst_b), .locked(locked_b), .pll_rst_out(pll_b),
    .unlock_cnt(cnt_b), .unlock_sticky(sticky_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode plus the edge index at which it was entered.
  int         m_mode;   // 0 = PLL reset pulse, 1 = waiting for lock, 2 = releasing/running
  int         m_t0, m_n, m_run, m_cnt8, m_cnt2;
  bit         m_sticky, m_locked, m_pll;
  logic [3:0] m_rst;
  bit         m_samp[$];

  task automatic model_edge();
    bit ls, lost;
    int k;
    logic [3:0] ones;
    if (rst_in) begin
      m_mode = 0; m_t0 = 0; m_n = 0; m_run = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
      m_samp.delete();
    end else begin
      m_samp.push_back(pll_lock_in);
      ls   = (m_n >= 2) ? m_samp[m_n-2] : 1'b0;
      lost = 0;
      if (m_mode == 0) begin
        if (m_n == m_t0 + PCYC) begin m_mode = 1; m_t0 = m_n; m_run = 0; end
      end else if (m_mode == 1) begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run == FILT) begin m_mode = 2; m_t0 = m_n; end
        else if (m_n - m_t0 == TMO) begin m_mode = 0; m_t0 = m_n; end
      end else if (!ls) begin
        lost = 1; m_mode = 1; m_t0 = m_n; m_run = 0;
      end
      if (unlock_clr) begin m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0; end
      if (lost) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        m_sticky = 1;
      end
      m_n++;
    end
    ones = 4'hF;
    if (m_mode == 2) begin
      k = ((m_n - 1) - m_t0) / GAP + 1;
      if (k > N) k = N;
      m_rst = ones << k;
      m_locked = (k == N);
    end else begin
      m_rst = ones;
      m_locked = 0;
    end
    m_pll = (m_mode == 0);
  endtask

  function automatic bit thermo(input logic [3:0] r);
    logic [3:0] ones = 4'hF;
    bit ok = 0;
    for (int k = 0; k <= 4; k++) if (r == (ones << k)) ok = 1;
    return ok;
  endfunction

  int edge_no = 0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    edge_no++;
    #1;
    check("dut_a", {17'd0, rst_a, locked_a, pll_a, sticky_a, cnt_a},
                   {17'd0, m_rst, m_locked, m_pll, m_sticky, 8'(m_cnt8)});
    check("dut_b", {17'd0, rst_b, locked_b, pll_b, sticky_b, 6'd0, cnt_b},
                   {17'd0, m_rst, m_locked, m_pll, m_sticky, 8'(m_cnt2)});
    check("order", 32'(thermo(rst_a)), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int e_pll, e_r0, e_r1, e_r2, e_r3, e_lk, s_edge, e_rel;
  int rises[$], falls[$];
  logic prev_pll;
  int hold;

  initial begin
    ticks(3);
    check("reset_rst_out", 32'(rst_a), 32'hF);
    check("reset_pll", 32'(pll_a), 32'd1);

    // Cold start: lock rises before edge 20.
    rst_in = 1'b0;
    edge_no = -1;
    e_pll = -1; e_r0 = -1; e_r1 = -1; e_r2 = -1; e_r3 = -1; e_lk = -1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (edge_no == 19) pll_lock_in = 1'b1;
      if (!pll_a && e_pll < 0) e_pll = edge_no;
      if (rst_a == 4'b1110 && e_r0 < 0) e_r0 = edge_no;
      if (rst_a == 4'b1100 && e_r1 < 0) e_r1 = edge_no;
      if (rst_a == 4'b1000 && e_r2 < 0) e_r2 = edge_no;
      if (rst_a == 4'b0000 && e_r3 < 0) e_r3 = edge_no;
      if (locked_a && e_lk < 0) e_lk = edge_no;
    end
    check("cold_pll_fall", 32'(e_pll), 32'd4);
    check("cold_rel0", 32'(e_r0), 32'd37);
    check("cold_rel1", 32'(e_r1), 32'd45);
    check("cold_rel2", 32'(e_r2), 32'd53);
    check("cold_rel3", 32'(e_r3), 32'd61);
    check("cold_locked", 32'(e_lk), 32'd61);

    // Lock loss in RUN for 3 cycles.
    pll_lock_in = 1'b0;
    ticks(3);
    check("loss_rst_out", 32'(rst_a), 32'hF);
    check("loss_locked", 32'(locked_a), 32'd0);
    check("loss_cnt", 32'(cnt_a), 32'd1);
    check("loss_sticky", 32'(sticky_a), 32'd1);
    pll_lock_in = 1'b1;
    ticks(60);
    check("relock", 32'(locked_a), 32'd1);

    // Glitchy lock: 10 high, 1 low, then steady.
    pll_lock_in = 1'b0;
    ticks(5);
    pll_lock_in = 1'b1;
    ticks(10);
    pll_lock_in = 1'b0;
    ticks(1);
    pll_lock_in = 1'b1;
    s_edge = edge_no + 1;
    e_rel = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rst_a != 4'hF && e_rel < 0) e_rel = edge_no;
    end
    check("glitch_release", 32'(e_rel - s_edge), 32'd17);

    // Loss mid-SEQUENCE, then a clear coinciding with a second loss.
    pll_lock_in = 1'b0;
    ticks(4);
    pll_lock_in = 1'b1;
    ticks(27);
    check("midseq_partial", 32'(rst_a), 32'b1100);
    pll_lock_in = 1'b0;
    ticks(2);
    unlock_clr = 1'b1;
    tick();
    unlock_clr = 1'b0;
    check("clr_loss_cnt", 32'(cnt_a), 32'd1);
    check("clr_loss_sticky", 32'(sticky_a), 32'd1);
    check("clr_loss_rst", 32'(rst_a), 32'hF);

    // Timeout: lock held low.
    prev_pll = pll_a;
    for (int i = 0; i < 2200; i++) begin
      tick();
      if (pll_a && !prev_pll) rises.push_back(edge_no);
      if (!pll_a && prev_pll) falls.push_back(edge_no);
      prev_pll = pll_a;
    end
    if (rises.size() >= 2 && falls.size() >= 1) begin
      check("timeout_first", 32'(rises[0] - (edge_no - 2200)), 32'd1000);
      check("timeout_period", 32'(rises[1] - rises[0]), 32'd1004);
      check("timeout_width", 32'(falls[0] - rises[0]), 32'd4);
    end else begin
      check("timeout_pulses", 32'(rises.size()), 32'd2);
    end
    check("timeout_rst_out", 32'(rst_a), 32'hF);

    // Saturation of the 2-bit counter.
    unlock_clr = 1'b1;
    tick();
    unlock_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pll_lock_in = 1'b1;
      ticks($urandom_range(60, 30));
      pll_lock_in = 1'b0;
      ticks($urandom_range(8, 3));
    end
    check("sat_cnt2", 32'(cnt_b), 32'd3);
    check("sat_cnt8", 32'(cnt_a), 32'd5);

    // Random lock activity and clears.
    for (int i = 0; i < 60; i++) begin
      pll_lock_in = 1'($urandom_range(1, 0));
      hold = $urandom_range(40, 1);
      for (int j = 0; j < hold; j++) begin
        unlock_clr = ($urandom_range(49, 0) == 0);
        tick();
      end
    end
    unlock_clr = 1'b0;

    // Asynchronous reset in RUN.
    pll_lock_in = 1'b1;
    ticks(70);
    check("pre_async_locked", 32'(locked_a), 32'd1);
    @(negedge clk);
    rst_in = 1'b1;
    #1;
    check("async_a", {17'd0, rst_a, locked_a, pll_a, sticky_a, cnt_a}, {17'd0, 4'hF, 1'b0, 1'b1, 1'b0, 8'd0});
    check("async_b", {26'd0, rst_b, locked_b, pll_b}, {26'd0, 4'hF, 1'b0, 1'b1});
    ticks(2);
    rst_in = 1'b0;
    ticks(70);
    check("post_async_locked", 32'(locked_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Parametrised clock-domain reset sequencer that sits directly behind a GateMate CC_PLL instance. It synchronises and debounces the PLL lock signal. It then releases N_CH reset channels one after another, so downstream blocks leave reset in a fixed order. It also re-pulses the PLL reset when lock is never reached, and counts lock-loss events for debug.

## Interface
Parameters:
- N_CH, 4: number of reset channels (1..16).
- SYNC_STAGES, 2: flops in the lock synchroniser (>=2).
- LOCK_FILTER, 16: consecutive synchronised-high cycles required before lock is accepted (>=1).
- STAGE_GAP, 8: cycles between successive channel releases (>=1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before the PLL is reset again (> LOCK_FILTER).
- PLL_RST_CYCLES, 4: width of the pll_rst_out pulse, in cycles (>=1).
- CNT_W, 8: width of the lock-loss counter.

Ports:
- clock_in  in  1  free-running clock, independent of PLL lock.
- rst_in  in  1  asynchronous, active-high reset.
- pll_lock_in  in  1  raw PLL lock, asynchronous to clock_in.
- unlock_clr  in  1  synchronous clear of unlock_cnt and unlock_sticky.
- rst_out  out  N_CH  per-channel active-high reset; bit 0 is released first.
- locked  out  1  high only in RUN, when all channels are released.
- pll_rst_out  out  1  active-high reset request to the PLL.
- unlock_cnt  out  CNT_W  saturating count of lock-loss events.
- unlock_sticky  out  1  set on any lock loss; held until unlock_clr.

## Operation
- pll_lock_in passes through a SYNC_STAGES flop chain; the last stage is lock_s. No other logic samples pll_lock_in.
- Reset values while rst_in is high: state=RESET_PLL, rst_out all ones, locked=0, pll_rst_out=1, unlock_cnt=0, unlock_sticky=0, all internal counters 0.
- RESET_PLL: pll_rst_out=1 for PLL_RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst_out=0.
- WAIT_LOCK:
  - The timeout counter increments every cycle.
  - The filter counter increments while lock_s=1 and clears to 0 on any lock_s=0.
  - When the filter counter reaches LOCK_FILTER, go to SEQUENCE.
  - If the timeout counter reaches LOCK_TIMEOUT first, go to RESET_PLL.
  - If both conditions occur on the same cycle, lock wins.
- SEQUENCE: a gap counter releases rst_out[k] k*STAGE_GAP cycles after entry. The release of rst_out[N_CH-1] coincides with entry to RUN and locked=1.
- RUN: hold state while lock_s=1.
- Lock loss is lock_s=0 while in SEQUENCE or RUN. On the next edge:
  - rst_out goes to all ones and locked to 0;
  - state goes to WAIT_LOCK, with the timeout and filter counters cleared;
  - unlock_cnt increments, saturating at all ones, and unlock_sticky goes to 1.
- Lock loss does not pulse pll_rst_out. Only a WAIT_LOCK timeout does.
- unlock_clr clears unlock_cnt and unlock_sticky on the next edge. If unlock_clr and a lock-loss event occur on the same cycle, the result is unlock_cnt=1 and unlock_sticky=1.
- Any rst_in assertion mid-sequence returns all outputs to their reset values immediately (asynchronously).
- rst_out bits are never released out of order. Once asserted, no bit deasserts before all lower bits are deasserted.

## Timing
- rst_in deasserts before edge 0 (edges are counted from the first clock_in edge after deassertion). pll_rst_out falls on edge PLL_RST_CYCLES.
- pll_lock_in rises stably before edge t. lock_s is high after edge t+SYNC_STAGES-1. Entry to SEQUENCE and the rst_out[0] release happen on edge t+SYNC_STAGES-1+LOCK_FILTER.
- With E0 as the SEQUENCE entry edge, rst_out[k] falls on edge E0+k*STAGE_GAP. locked rises on E0+(N_CH-1)*STAGE_GAP. For N_CH=1, locked and rst_out[0] change together on E0.
- From lock_s falling to all rst_out reasserted: 1 edge. From pll_lock_in falling: SYNC_STAGES edges.
- All outputs are registered, with no combinational path from any input.

## Test plan
All scenarios use N_CH=4, SYNC_STAGES=2, LOCK_FILTER=16, STAGE_GAP=8, LOCK_TIMEOUT=1000 and PLL_RST_CYCLES=4 unless stated otherwise.
- Cold start: release rst_in, raise pll_lock_in at edge 20 -> pll_rst_out low at edge 4; rst_out 1111->1110 at edge 37; then 1100 at 45, 1000 at 53, 0000 at 61 with locked=1.
- Glitchy lock: hold pll_lock_in high 10 cycles, low 1 cycle, then steady high -> the filter restarts; no release until 16 consecutive synchronised-high cycles.
- Timeout: hold pll_lock_in low -> pll_rst_out pulses 4 cycles wide every 1004 cycles; rst_out stays 1111.
- Lock loss in RUN: drop pll_lock_in for 3 cycles -> rst_out=1111 and locked=0 two edges later; unlock_cnt=1, unlock_sticky=1; the full sequence repeats after lock returns.
- Lock loss mid-SEQUENCE, plus unlock_clr coinciding with a second loss -> all channels reassert with no out-of-order release; unlock_cnt=1 and unlock_sticky=1 after the clear.
- Counter saturation with CNT_W=2: 5 lock-loss events -> unlock_cnt holds at 3. A mid-RUN rst_in pulse -> all outputs return to reset values asynchronously.
